// File: rtl/ro_count_reader.sv
// ro_count_reader: gates a ring oscillator for a programmed number of
// count_clk cycles, waits for the counter to settle, then samples the
// 15-bit count until two consecutive samples agree. A retry budget of three
// compares bounds the sampling. The result is held until the consumer
// accepts it.
// Optional feature: define RO_READER_AVG_EN to run four gate/settle/sample
// passes per request and report the average count.
module ro_count_reader #(
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              count_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [6:0]        cnt_lo,
  input  logic [7:0]        cnt_hi,
  output logic              ro_en,
  output logic              busy,
  output logic [14:0]       result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  // A zero settle length still waits one cycle.
  localparam int SET_N = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int SET_W = (SET_N > 1) ? $clog2(SET_N) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SET_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_SETTLE,
    S_SAMPLE,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [14:0]       samp_q, samp_d;
  logic              phase_q, phase_d;
  logic [1:0]        tries_q, tries_d;
  logic              ro_en_q, ro_en_d;
  logic [14:0]       result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              err_q, err_d;

`ifdef RO_READER_AVG_EN
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [16:0]       acc_q, acc_d;
  logic [1:0]        pass_q, pass_d;
  logic              err_acc_q, err_acc_d;
  logic [16:0]       acc_sum;
  logic              err_all;
`endif

  logic [14:0] bus;
  logic        done;
  logic        done_err;

  assign bus = {cnt_hi, cnt_lo};

  // Gate length zero is treated as one cycle; the counter holds cycles left minus one.
  function automatic logic [GATE_W-1:0] gate_reload(input logic [GATE_W-1:0] len);
    return (len == '0) ? '0 : len - GATE_W'(1);
  endfunction

  // Next-state and datapath decisions for the measurement sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    samp_d         = samp_q;
    phase_d        = phase_q;
    tries_d        = tries_q;
    ro_en_d        = ro_en_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    done           = 1'b0;
    done_err       = 1'b0;
`ifdef RO_READER_AVG_EN
    gate_len_d     = gate_len_q;
    acc_d          = acc_q;
    pass_d         = pass_q;
    err_acc_d      = err_acc_q;
    acc_sum        = '0;
    err_all        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          gate_cnt_d = gate_reload(gate_len);
          ro_en_d    = 1'b1;
          state_d    = S_GATE;
`ifdef RO_READER_AVG_EN
          gate_len_d = gate_len;
          acc_d      = '0;
          pass_d     = '0;
          err_acc_d  = 1'b0;
`endif
        end
      end

      S_GATE: begin
        if (gate_cnt_q == '0) begin
          ro_en_d      = 1'b0;
          settle_cnt_d = SET_LOAD;
          state_d      = S_SETTLE;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          phase_d = 1'b0;
          tries_d = '0;
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end

      S_SAMPLE: begin
        // The first cycle only captures; later cycles compare the bus
        // against the previous capture and slide the window on a mismatch.
        if (!phase_q) begin
          samp_d  = bus;
          phase_d = 1'b1;
        end else if (bus == samp_q) begin
          done = 1'b1;
        end else if (tries_q == 2'd2) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          tries_d = tries_q + 2'd1;
          samp_d  = bus;
        end
      end

      S_HOLD: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (done) begin
`ifdef RO_READER_AVG_EN
      acc_sum = acc_q + {2'b00, bus};
      err_all = err_acc_q | done_err;
      if (pass_q == 2'd3) begin
        result_d       = acc_sum[16:2];
        err_d          = err_all;
        result_valid_d = 1'b1;
        state_d        = S_HOLD;
      end else begin
        acc_d      = acc_sum;
        err_acc_d  = err_all;
        pass_d     = pass_q + 2'd1;
        gate_cnt_d = gate_reload(gate_len_q);
        ro_en_d    = 1'b1;
        state_d    = S_GATE;
      end
`else
      result_d       = bus;
      err_d          = done_err;
      result_valid_d = 1'b1;
      state_d        = S_HOLD;
`endif
    end
  end

  // State and datapath registers; reset drops ro_en and discards any partial measurement.
  // NOTE: reset is asynchronous so ro_en falls without waiting for a clock edge.
  always_ff @(posedge count_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      gate_cnt_q     <= '0;
      settle_cnt_q   <= '0;
      samp_q         <= '0;
      phase_q        <= 1'b0;
      tries_q        <= '0;
      ro_en_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
`ifdef RO_READER_AVG_EN
      gate_len_q     <= '0;
      acc_q          <= '0;
      pass_q         <= '0;
      err_acc_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // values sampled before the edge.
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      samp_q         <= samp_d;
      phase_q        <= phase_d;
      tries_q        <= tries_d;
      ro_en_q        <= ro_en_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
`ifdef RO_READER_AVG_EN
      gate_len_q     <= gate_len_d;
      acc_q          <= acc_d;
      pass_q         <= pass_d;
      err_acc_q      <= err_acc_d;
`endif
    end
  end

  assign ro_en        = ro_en_q;
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ro_count_reader.sv
// Directed bench for ro_count_reader. Expected results are queued when a
// measurement is started and compared when result_valid appears.
module tb_ro_count_reader;

  localparam int GW = 16;
  localparam int SC = 4;

  typedef struct {
    logic [14:0] res;
    logic        err;
    int          lat;
    int          hi;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] gate_len_i = '0;
  logic [14:0]   bus = '0;
  logic [6:0]    cnt_lo;
  logic [7:0]    cnt_hi;
  logic          ro_en;
  logic          busy;
  logic [14:0]   result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  assign cnt_lo = bus[6:0];
  assign cnt_hi = bus[14:7];

  always #5 clk = ~clk;

  ro_count_reader #(.GATE_W(GW), .SETTLE_CYC(SC)) dut (
    .count_clk    (clk),
    .rst_n        (rst_n),
    .start        (start),
    .gate_len     (gate_len_i),
    .cnt_lo       (cnt_lo),
    .cnt_hi       (cnt_hi),
    .ro_en        (ro_en),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One measurement: queue the expectation, start, follow the DUT cycle by
  // cycle until result_valid, then exercise HOLD and the handshake.
  task automatic run(input string name, input logic [GW-1:0] glen, input logic [14:0] base,
                     input bit tog, input int hold_cyc, input bit poke);
    exp_t e;
    exp_t got_e;
    int   n;
    int   c;
    int   hi;
    bit   got;
    n     = (glen == '0) ? 1 : int'(glen);
    e.lat = tog ? n + SC + 4 : n + SC + 2;
    e.res = tog ? 15'(base + 15'(e.lat)) : base;
    e.err = tog;
    e.hi  = n;
    sb.push_back(e);

    @(negedge clk);
    bus        = base;
    gate_len_i = glen;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hi  = 0;
    got = 1'b0;
    c   = 0;
    while (!got && c < 3000) begin
      if (ro_en) hi++;
      if (result_valid) got = 1'b1;
      else begin
        if (tog) bus = 15'(base + 15'(c + 1));
        @(posedge clk);
        #1 c++;
      end
    end
    check({name, " valid_seen"}, 32'(got), 32'd1);
    if (got) begin
      got_e = sb.pop_front();
      check({name, " result"},  32'(result), 32'(got_e.res));
      check({name, " err"},     32'(err),    32'(got_e.err));
      check({name, " latency"}, 32'(c),      32'(got_e.lat));
      check({name, " ro_en_hi"}, 32'(hi),    32'(got_e.hi));
      for (int i = 0; i < hold_cyc; i++) begin
        start = poke && (i % 5 == 0);
        @(posedge clk);
        #1 start = 1'b0;
        check({name, " hold_valid"},  32'(result_valid), 32'd1);
        check({name, " hold_result"}, 32'(result),       32'(got_e.res));
        check({name, " hold_busy"},   32'(busy),         32'd1);
      end
      result_ready = 1'b1;
      start        = poke;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      start        = 1'b0;
      check({name, " ack_valid"}, 32'(result_valid), 32'd0);
      check({name, " ack_busy"},  32'(busy),         32'd0);
      repeat (3) @(posedge clk);
      #1 check({name, " idle_after"}, 32'(busy), 32'd0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst ro_en", 32'(ro_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst valid", 32'(result_valid), 32'd0);
    check("rst err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef RO_READER_AVG_EN
    begin
      // Four passes with counts 100..103 average to 101.
      logic [14:0] vals [4];
      exp_t        e;
      exp_t        g;
      int          p;
      int          c;
      bit          prev;
      bit          got;
      vals[0] = 15'd100; vals[1] = 15'd101; vals[2] = 15'd102; vals[3] = 15'd103;
      e.res = 15'd101; e.err = 1'b0; e.lat = 0; e.hi = 0;
      sb.push_back(e);
      @(negedge clk);
      gate_len_i = 16'd10;
      bus        = 15'd0;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      p = 0; c = 0; prev = 1'b0; got = 1'b0;
      while (!got && c < 2000) begin
        if (ro_en && !prev && p < 4) begin
          bus = vals[p];
          p++;
        end
        prev = ro_en;
        if (result_valid) got = 1'b1;
        else begin
          @(posedge clk);
          #1 c++;
        end
      end
      check("avg valid_seen", 32'(got), 32'd1);
      check("avg passes", 32'(p), 32'd4);
      g = sb.pop_front();
      check("avg result", 32'(result), 32'(g.res));
      check("avg err", 32'(err), 32'(g.err));
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      check("avg ack_valid", 32'(result_valid), 32'd0);
    end
`else
    run("g100", 16'd100, 15'h1234, 1'b0, 0, 1'b0);
    run("g0", 16'd0, 15'h0055, 1'b0, 0, 1'b0);
    run("toggle", 16'd5, 15'h0100, 1'b1, 0, 1'b0);
    run("hold", 16'd3, 15'h7fff, 1'b0, 20, 1'b1);
`endif

    // Reset in the middle of GATE.
    @(negedge clk);
    gate_len_i = 16'd50;
    bus        = 15'h0aaa;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("mid ro_en_before", 32'(ro_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid ro_en", 32'(ro_en), 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    check("mid result", 32'(result), 32'd0);
    check("mid valid", 32'(result_valid), 32'd0);
    check("mid err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_valid;
      int seen_busy;
      seen_valid = 0;
      seen_busy  = 0;
      repeat (150) begin
        @(posedge clk);
        #1;
        if (result_valid) seen_valid++;
        if (busy) seen_busy++;
      end
      check("post_rst no_valid", 32'(seen_valid), 32'd0);
      check("post_rst idle", 32'(seen_busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_count_reader.md
RO_COUNT_READER -- requirements
Module: ro_count_reader

Interface
REQ-001 The block SHALL have parameter GATE_W, default 16, meaning the width of the gate-length counter and of gate_len.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 4, meaning the number of count_clk cycles waited after the gate closes before sampling.
REQ-003 The block SHALL have port count_clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: measurement request, sampled in IDLE only.
REQ-006 The block SHALL have port gate_len, input, GATE_W bits: gate window length in count_clk cycles, latched on start.
REQ-007 The block SHALL have port cnt_lo, input, 7 bits: counter bits [6:0] from the oscillator block's uo_out[7:1].
REQ-008 The block SHALL have port cnt_hi, input, 8 bits: counter bits [14:7] from the oscillator block's uio_out.
REQ-009 The block SHALL have port ro_en, output, 1 bit: registered enable driven to the oscillator block's ui_in[0].
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port result, output, 15 bits: measured count, valid while result_valid=1.
REQ-012 The block SHALL have port result_valid, output, 1 bit: result available.
REQ-013 The block SHALL have port result_ready, input, 1 bit: consumer acceptance.
REQ-014 The block SHALL have port err, output, 1 bit: set together with result_valid when the sample never stabilised.

Function
REQ-015 The block SHALL implement states IDLE, GATE, SETTLE, SAMPLE and HOLD.
REQ-016 IDLE with start=1 at edge k SHALL latch gate_len, set ro_en=1 from edge k, and go to GATE.
REQ-017 ro_en SHALL stay high for exactly max(gate_len,1) cycles, so gate_len=0 is treated as 1, and then fall, entering SETTLE.
REQ-018 SETTLE SHALL hold ro_en=0 for SETTLE_CYC cycles (0 is treated as 1), then enter SAMPLE.
REQ-019 SAMPLE SHALL register {cnt_hi,cnt_lo} on two consecutive cycles; if both are equal, it SHALL load result, clear err and go to HOLD.
REQ-020 On a mismatch, SAMPLE SHALL retry the compare up to 3 attempts total, then load the last sample with err=1 and go to HOLD.
REQ-021 HOLD SHALL assert result_valid with result and err stable; when result_valid and result_ready are both high at an edge, it SHALL clear result_valid and return to IDLE.
REQ-022 start outside IDLE SHALL be ignored and SHALL NOT be queued; start on the same edge as the HOLD handshake SHALL be ignored.
REQ-023 Minimum latency from start to result_valid with N=max(gate_len,1) and stable inputs SHALL be N+SETTLE_CYC+2 cycles.
REQ-024 The counter value SHALL be 15 bits; oscillator wrap-around within a gate SHALL NOT be detected and is reported modulo 2^15.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously force state=IDLE, ro_en=0, busy=0, result=0, result_valid=0, err=0, and clear all counters.
REQ-026 Reset asserted mid-operation SHALL drop ro_en immediately and discard any partial measurement; after reset the block SHALL wait in IDLE for a new start.

Configuration
REQ-027 When RO_READER_AVG_EN is defined, each accepted start SHALL run 4 complete GATE/SETTLE/SAMPLE passes into a 17-bit accumulator, result SHALL be accumulator[16:2], and err SHALL be the OR across the 4 passes.
REQ-028 When RO_READER_AVG_EN is not defined, the block SHALL run a single pass, and no accumulator logic SHALL exist.

Verification
REQ-029 Bench SHALL cover: gate_len=100, bus held 0x1234 after the gate -> ro_en high exactly 100 cycles, result=0x1234, err=0, result_valid at cycle 106.
REQ-030 Bench SHALL cover: gate_len=0 -> ro_en high exactly 1 cycle, flow completes normally.
REQ-031 Bench SHALL cover: bus toggling every cycle during SAMPLE -> err=1 after 3 attempts, result equals last sample.
REQ-032 Bench SHALL cover: result_ready=0 for 20 cycles in HOLD with start pulsed -> result stable, start ignored, then handshake returns the block to IDLE.
REQ-033 Bench SHALL cover: rst_n low during GATE -> ro_en=0 asynchronously, all outputs at reset values, no result_valid afterwards.
REQ-034 Bench SHALL cover: with RO_READER_AVG_EN, pass counts 100,101,102,103 -> result=101.
